// File: rtl/alu_operand_stage.sv
`default_nettype none
// ============================================================================
// Module   : alu_operand_stage
// Purpose  : Operand-fetch stage in front of an external ALU. Holds a
//            32 x 32 register file, and reads source operands for each
//            accepted request into a single-entry pipeline register that
//            drives the ALU. It writes the returned ALU result back into the
//            register file when the operation retires.
// Config   : ALU_OPERAND_FORWARD_EN
//              defined   - a read-after-write hazard with the retiring op is
//                          resolved by forwarding alu_y into the operand(s)
//              undefined - the same hazard stalls the request for one cycle
// Revision : 1.0 - initial release
// ============================================================================
module alu_operand_stage (
   input  logic        clk,
   input  logic        reset_n,
   // request side
   input  logic        in_valid,
   output logic        in_ready,
   input  logic [3:0]  in_op,
   input  logic [4:0]  in_rs,
   input  logic [4:0]  in_rt,
   input  logic [4:0]  in_rd,
   input  logic [31:0] in_imm,
   input  logic        in_use_imm,
   // operands to the downstream ALU
   output logic [3:0]  alu_op,
   output logic [31:0] alu_a,
   output logic [31:0] alu_b,
   input  logic [31:0] alu_y,
   input  logic        alu_z,
   output logic        out_valid,
   input  logic        out_ready,
   output logic        zero_flag,
   // test read port
   input  logic [4:0]  dbg_addr,
   output logic [31:0] dbg_data
);

   // Register storage. Entry 0 is never written and all reads of address 0
   // are forced to zero, so its content never matters.
   logic [31:0] regs [0:31];

   // Destination of the operation currently held in the output register.
   logic [4:0]  pend_rd;

   logic        accept;
   logic        retire;
   logic        wb_en;
   logic        hit_rs;
   logic        hit_rt;
   logic        hazard;
   logic [31:0] rf_a;
   logic [31:0] rf_b;
   logic [31:0] opnd_a;
   logic [31:0] opnd_b;

   // Read ports. Each one returns the stored value, so it shows the
   // contents before any write that lands on this clock edge.
   assign rf_a     = (in_rs    == 5'd0) ? 32'd0 : regs[in_rs];
   assign rf_b     = (in_rt    == 5'd0) ? 32'd0 : regs[in_rt];
   assign dbg_data = (dbg_addr == 5'd0) ? 32'd0 : regs[dbg_addr];

   // A writeback happens only on retire, and never to register 0.
   assign retire = out_valid & out_ready;
   assign wb_en  = retire & (pend_rd != 5'd0);

   // The incoming request reads a register that the retiring op writes this
   // cycle. rt counts only when the B operand really comes from rt.
   assign hit_rs = wb_en & (pend_rd == in_rs);
   assign hit_rt = wb_en & ~in_use_imm & (pend_rd == in_rt);
   assign hazard = hit_rs | hit_rt;

`ifdef ALU_OPERAND_FORWARD_EN
   // Forward the result being written back in place of the stale value.
   // The request still goes through without a stall.
   assign opnd_a   = hit_rs ? alu_y : rf_a;
   assign opnd_b   = in_use_imm ? in_imm : (hit_rt ? alu_y : rf_b);
   assign in_ready = reset_n & (~out_valid | out_ready);
`else
   // Stall one cycle on a hazard. On the next cycle the request reads the
   // value that was just written.
   assign opnd_a   = rf_a;
   assign opnd_b   = in_use_imm ? in_imm : rf_b;
   assign in_ready = reset_n & (~out_valid | out_ready) & ~hazard;
`endif

   assign accept = in_valid & in_ready;

   // Pipeline register: load new operands on accept, drop the entry on a
   // retire that has no replacement, and hold the entry otherwise.
   always_ff @(posedge clk) begin
      if (!reset_n) begin
         out_valid <= 1'b0;
         alu_op    <= 4'd0;
         alu_a     <= 32'd0;
         alu_b     <= 32'd0;
         pend_rd   <= 5'd0;
      end else if (accept) begin
         out_valid <= 1'b1;
         alu_op    <= in_op;
         alu_a     <= opnd_a;
         alu_b     <= opnd_b;
         pend_rd   <= in_rd;
      end else if (retire) begin
         out_valid <= 1'b0;
      end
   end

   // Zero flag tracks alu_z at each retire, including retires to rd = 0.
   always_ff @(posedge clk) begin
      if (!reset_n) begin
         zero_flag <= 1'b0;
      end else if (retire) begin
         zero_flag <= alu_z;
      end
   end

   // Register-file writeback. Reset takes priority, so an op that is in
   // flight when reset arrives is discarded without being written.
   always_ff @(posedge clk) begin
      if (!reset_n) begin
         for (int i = 0; i < 32; i++) begin
            regs[i] <= 32'd0;
         end
      end else if (wb_en) begin
         regs[pend_rd] <= alu_y;
      end
   end

endmodule
`default_nettype wire

// File: tb/tb_alu_operand_stage.sv
`default_nettype none
// ============================================================================
// Module   : tb_alu_operand_stage
// Purpose  : Directed, self-checking bench for alu_operand_stage. It covers
//            reset, first-op latency, a back-to-back RAW hazard (in both
//            build variants), backpressure, writes to register 0, the zero
//            flag, and reset while an op is in flight.
// Revision : 1.0 - initial release
// ============================================================================
module tb_alu_operand_stage;

   logic        clk;
   logic        reset_n;
   logic        in_valid;
   logic        in_ready;
   logic [3:0]  in_op;
   logic [4:0]  in_rs;
   logic [4:0]  in_rt;
   logic [4:0]  in_rd;
   logic [31:0] in_imm;
   logic        in_use_imm;
   logic [3:0]  alu_op;
   logic [31:0] alu_a;
   logic [31:0] alu_b;
   logic [31:0] alu_y;
   logic        alu_z;
   logic        out_valid;
   logic        out_ready;
   logic        zero_flag;
   logic [4:0]  dbg_addr;
   logic [31:0] dbg_data;

   int checks   = 0;
   int failures = 0;

   alu_operand_stage dut (
      .clk        (clk),
      .reset_n    (reset_n),
      .in_valid   (in_valid),
      .in_ready   (in_ready),
      .in_op      (in_op),
      .in_rs      (in_rs),
      .in_rt      (in_rt),
      .in_rd      (in_rd),
      .in_imm     (in_imm),
      .in_use_imm (in_use_imm),
      .alu_op     (alu_op),
      .alu_a      (alu_a),
      .alu_b      (alu_b),
      .alu_y      (alu_y),
      .alu_z      (alu_z),
      .out_valid  (out_valid),
      .out_ready  (out_ready),
      .zero_flag  (zero_flag),
      .dbg_addr   (dbg_addr),
      .dbg_data   (dbg_data)
   );

   // 10 ns clock
   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Single comparison point: count it and report any mismatch.
   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         failures++;
         $display("FAIL %s: got=%h expected=%h", tag, got, exp);
      end
   endtask

   // Advance past the next rising edge; inputs change and outputs are sampled
   // 1 ns later, well away from the edge.
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Read a register through the debug port.
   task automatic peek(input logic [4:0] addr, output logic [31:0] val);
      dbg_addr = addr;
      #1;
      val = dbg_data;
   endtask

   // Present one request on the input side.
   task automatic req(input logic [3:0] op, input logic [4:0] rs, input logic [4:0] rt,
                      input logic [4:0] rd, input logic use_imm, input logic [31:0] imm);
      in_valid   = 1'b1;
      in_op      = op;
      in_rs      = rs;
      in_rt      = rt;
      in_rd      = rd;
      in_use_imm = use_imm;
      in_imm     = imm;
   endtask

   logic [31:0] rv;

   initial begin
      reset_n    = 1'b0;
      in_valid   = 1'b0;
      in_op      = 4'd0;
      in_rs      = 5'd0;
      in_rt      = 5'd0;
      in_rd      = 5'd0;
      in_imm     = 32'd0;
      in_use_imm = 1'b0;
      alu_y      = 32'd0;
      alu_z      = 1'b0;
      out_ready  = 1'b0;
      dbg_addr   = 5'd0;

      // ---------------- reset state ----------------
      tick();
      tick();
      check("rst_out_valid", {31'd0, out_valid}, 32'd0);
      check("rst_alu_op",    {28'd0, alu_op},    32'd0);
      check("rst_alu_a",     alu_a,              32'd0);
      check("rst_alu_b",     alu_b,              32'd0);
      check("rst_zero_flag", {31'd0, zero_flag}, 32'd0);
      check("rst_in_ready",  {31'd0, in_ready},  32'd0);

      reset_n = 1'b1;
      #1;
      check("rel_in_ready", {31'd0, in_ready}, 32'd1);

      // ---------------- first op: r1 = 0 + 5 ----------------
      req(4'b0000, 5'd0, 5'd0, 5'd1, 1'b1, 32'd5);
      tick();
      check("op1_out_valid", {31'd0, out_valid}, 32'd1);
      check("op1_alu_a",     alu_a,              32'd0);
      check("op1_alu_b",     alu_b,              32'd5);

      // ---------------- back-to-back RAW on r1 ----------------
      req(4'b0000, 5'd1, 5'd0, 5'd2, 1'b1, 32'd3);
      out_ready = 1'b1;
      alu_y     = 32'd5;
      alu_z     = 1'b0;
      #1;
`ifdef ALU_OPERAND_FORWARD_EN
      check("fwd_in_ready", {31'd0, in_ready}, 32'd1);
      tick();
`else
      check("haz_in_ready", {31'd0, in_ready}, 32'd0);
      tick();
      check("haz_bubble_valid", {31'd0, out_valid}, 32'd0);
      check("haz_in_ready_next", {31'd0, in_ready}, 32'd1);
      tick();
`endif
      check("op2_out_valid", {31'd0, out_valid}, 32'd1);
      check("op2_alu_a",     alu_a,              32'd5);
      check("op2_alu_b",     alu_b,              32'd3);
      check("op1_zero_flag", {31'd0, zero_flag}, 32'd0);
      peek(5'd1, rv);
      check("wb_r1", rv, 32'd5);

      // ---------------- backpressure for 4 cycles ----------------
      req(4'b0001, 5'd1, 5'd1, 5'd0, 1'b0, 32'd7);
      out_ready = 1'b0;
      alu_y     = 32'd8;
      alu_z     = 1'b0;
      for (int i = 0; i < 4; i++) begin
         #1;
         check("bp_in_ready",  {31'd0, in_ready},  32'd0);
         tick();
         check("bp_out_valid", {31'd0, out_valid}, 32'd1);
         check("bp_alu_op",    {28'd0, alu_op},    32'd0);
         check("bp_alu_a",     alu_a,              32'd5);
         check("bp_alu_b",     alu_b,              32'd3);
         peek(5'd2, rv);
         check("bp_no_wb_r2", rv, 32'd0);
      end
      // release: r2 = 8 retires, and the rt-sourced request enters
      out_ready = 1'b1;
      #1;
      check("bp_rel_in_ready", {31'd0, in_ready}, 32'd1);
      tick();
      peek(5'd2, rv);
      check("wb_r2",       rv,              32'd8);
      check("op3_alu_op",  {28'd0, alu_op}, 32'd1);
      check("op3_alu_a",   alu_a,           32'd5);
      check("op3_alu_b",   alu_b,           32'd5);

      // ---------------- retire to rd=0, accept subtract ----------------
      req(4'b0010, 5'd1, 5'd0, 5'd3, 1'b1, 32'd5);
      alu_y = 32'hFFFF_FFFF;
      alu_z = 1'b0;
      tick();
      peek(5'd0, rv);
      check("r0_stays_zero", rv,                 32'd0);
      check("r0_zero_flag",  {31'd0, zero_flag}, 32'd0);
      check("sub_alu_op",    {28'd0, alu_op},    32'd2);
      check("sub_alu_a",     alu_a,              32'd5);
      check("sub_alu_b",     alu_b,              32'd5);

      // ---------------- subtract retires: r3 = 0, Z = 1 ----------------
      in_valid = 1'b0;
      alu_y    = 32'd0;
      alu_z    = 1'b1;
      tick();
      check("sub_zero_flag", {31'd0, zero_flag}, 32'd1);
      check("sub_drained",   {31'd0, out_valid}, 32'd0);
      peek(5'd3, rv);
      check("wb_r3", rv, 32'd0);

      // ---------------- reset with an op in flight ----------------
      req(4'b0010, 5'd2, 5'd0, 5'd3, 1'b1, 32'd5);
      tick();
      check("inflt_valid", {31'd0, out_valid}, 32'd1);
      check("inflt_alu_a", alu_a,              32'd8);
      in_valid  = 1'b0;
      out_ready = 1'b1;
      alu_y     = 32'd3;
      alu_z     = 1'b0;
      reset_n   = 1'b0;
      tick();
      check("mrst_out_valid", {31'd0, out_valid}, 32'd0);
      check("mrst_zero_flag", {31'd0, zero_flag}, 32'd0);
      check("mrst_alu_a",     alu_a,              32'd0);
      check("mrst_in_ready",  {31'd0, in_ready},  32'd0);
      peek(5'd3, rv);
      check("mrst_r3", rv, 32'd0);
      peek(5'd2, rv);
      check("mrst_r2", rv, 32'd0);
      reset_n = 1'b1;
      #1;
      check("mrst_rel_in_ready", {31'd0, in_ready}, 32'd1);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

   // Guard against a stuck run.
   initial begin
      #100000;
      $display("FAIL timeout: got=running expected=finished");
      $fatal(1);
   end

endmodule
`default_nettype wire

// File: doc/alu_operand_stage.md
ALU_OPERAND_STAGE -- requirements
Module: alu_operand_stage

Interface
REQ-001 The block SHALL use one clock and a synchronous, active-low reset; all state SHALL update only on the rising edge of clk.
REQ-002 clk  input  1  rising-edge clock.
REQ-003 reset_n  input  1  synchronous active-low reset.
REQ-004 in_valid  input  1  request present; in_ready  output  1  stage accepts request this cycle.
REQ-005 in_op  input  4  ALU opcode, passed through unchanged; in_rs, in_rt, in_rd  input  5 each  source A, source B, destination register.
REQ-006 in_imm  input  32  immediate; in_use_imm  input  1  B operand = in_imm instead of reg[in_rt].
REQ-007 alu_op  output  4, alu_a  output  32, alu_b  output  32  registered operands driving the downstream ALU.
REQ-008 alu_y  input  32, alu_z  input  1  combinational ALU result and zero flag returned for writeback.
REQ-009 out_valid  output  1  alu_op/alu_a/alu_b hold a live operation; out_ready  input  1  consumer takes it this cycle.
REQ-010 zero_flag  output  1  alu_z captured at the most recent retire.
REQ-011 dbg_addr  input  5, dbg_data  output  32  combinational register-file read port for test.

Function
REQ-012 Register file: 32 x 32 bit, two combinational read ports and one write port; reg[0] SHALL always read 0 and ignore writes.
REQ-013 Accept = in_valid & in_ready; retire = out_valid & out_ready.
REQ-014 Without a hazard, in_ready SHALL equal ~out_valid | out_ready (single-entry pipeline register, full throughput).
REQ-015 On accept, the stage SHALL capture alu_op = in_op, alu_a = reg[in_rs], alu_b = in_use_imm ? in_imm : reg[in_rt], and the pending rd, and SHALL set out_valid the next cycle (latency 1).
REQ-016 On retire, the stage SHALL write alu_y into reg[pending rd] (suppressed for rd = 0) and capture alu_z into zero_flag.
REQ-017 If retire occurs without accept, out_valid SHALL clear; if both occur, out_valid SHALL stay 1 with the new operands.
REQ-018 While out_valid & ~out_ready, alu_op/alu_a/alu_b SHALL hold stable and in_ready SHALL be 0.
REQ-019 Hazard = retire this cycle with pending rd != 0 and pending rd equal to in_rs, or to in_rt with in_use_imm = 0.
REQ-020 dbg_data SHALL show the register file contents before the write of the current cycle.
REQ-021 The block SHALL not interpret in_op; all arithmetic is downstream.

Reset
REQ-022 When reset_n = 0 at a clock edge: out_valid = 0, alu_op = 0, alu_a = 0, alu_b = 0, zero_flag = 0, all registers = 0.
REQ-023 Reset during an in-flight operation SHALL discard it with no writeback, even if out_ready = 1 that cycle.
REQ-024 in_ready SHALL be 0 while reset_n = 0 and 1 on the first cycle after release (subject to in_valid only).

Configuration
REQ-025 Macro ALU_OPERAND_FORWARD_EN defined: on a hazard, the request SHALL be accepted and the matching operand(s) SHALL take alu_y instead of the stale register value; in_ready unaffected by hazards.
REQ-026 Macro ALU_OPERAND_FORWARD_EN undefined: on a hazard, in_ready SHALL be 0 for that cycle; the request is accepted the next cycle reading the written value (one bubble).
REQ-027 Both builds SHALL produce identical register-file contents for the same accepted instruction sequence.

Verification
REQ-028 Reset, then request op=4'b0000, rs=0, rt=0, use_imm=1, imm=5, rd=1 -> next cycle out_valid=1, alu_a=0, alu_b=5; ALU returns 5 with out_ready=1 -> dbg reg1 = 5, zero_flag = 0.
REQ-029 Back-to-back: reg1=5 pending, next request rs=1, use_imm=1, imm=3, rd=2 arrives on retire cycle -> FORWARD_EN: accepted, alu_a=5, reg2=8; no FORWARD_EN: in_ready=0 one cycle, then alu_a=5, reg2=8.
REQ-030 Backpressure: out_ready=0 for 4 cycles with out_valid=1 -> in_ready=0, alu_a/alu_b/alu_op unchanged, no writeback until out_ready=1.
REQ-031 Write to rd=0 with alu_y=32'hFFFF_FFFF -> dbg reg0 reads 0; zero_flag follows alu_z (0).
REQ-032 Subtract op=4'b0010 of reg1=5 minus imm=5 into rd=3 -> reg3 = 0, zero_flag = 1; then reset_n=0 for one cycle with op in flight -> out_valid=0, zero_flag=0, reg3=0, no writeback.
